// File: rtl/vote_pkg.sv
// Shared types for the vote tally controller: FSM state encoding and decision-rule selectors.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_HOLD
    } state_t;

    localparam int MODE_MAJORITY  = 0;
    localparam int MODE_UNANIMOUS = 1;
    localparam int MODE_ANY       = 2;

endpackage

// File: rtl/cast_debounce.sv
// Cast pushbutton conditioning: 2-flop synchronizer, tick-paced DEB_N-sample filter,
// and a single-cycle pulse on the first cycle the filtered level is high.
module cast_debounce #(
    parameter int DEB_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic cast_raw,
    output logic cast_level,
    output logic cast_rise
);

    localparam int CNT_W = $clog2(DEB_N + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter tracks consecutive ticks disagreeing with the accepted level;
    // one agreeing tick restarts the run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick_en) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEB_N - 1)) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= cast_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign cast_level = level_q;
    assign cast_rise  = level_q & ~prev_q;

endmodule

// File: rtl/vote_tally_ctrl.sv
// Voting round controller: latches a ballot on each debounced cast press, decides it
// under the MODE rule and keeps saturating pass/fail tallies.
module vote_tally_ctrl
    import vote_pkg::*;
#(
    parameter int N_VOTERS = 3,
    parameter int COUNT_W  = 4,
    parameter int MODE     = 0,
    parameter int DEB_N    = 4
) (
    input  logic                             clk100MHz,
    input  logic                             rst,
    input  logic                             tick_en,
    input  logic [N_VOTERS-1:0]              vote_in,
    input  logic                             cast,
    input  logic                             clr,
    output logic [COUNT_W-1:0]               pass_cnt,
    output logic [COUNT_W-1:0]               fail_cnt,
    output logic [$clog2(N_VOTERS+1)-1:0]    yes_cnt,
    output logic                             result,
    output logic                             result_valid,
    output logic                             busy,
    output logic                             sat
);

    localparam int YES_W = $clog2(N_VOTERS + 1);

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] vsync1_q, vsync2_q;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [YES_W-1:0]    yes_q, yes_d;
    logic                result_q, result_d;
    logic [COUNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic                sat_q, sat_d, sat_hit;
    logic                cast_level, cast_rise;

    function automatic logic [YES_W-1:0] popcount(input logic [N_VOTERS-1:0] b);
        logic [YES_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_VOTERS; i++) n = n + YES_W'(b[i]);
        return n;
    endfunction

    function automatic logic decide(input logic [YES_W-1:0] yes);
        logic [YES_W:0] dbl;
        dbl = {yes, 1'b0};
        case (MODE)
            MODE_UNANIMOUS: return yes == YES_W'(N_VOTERS);
            MODE_ANY:       return yes != '0;
            default:        return dbl > (YES_W + 1)'(N_VOTERS);
        endcase
    endfunction

    // MSB flags an increment attempted at full scale; the count then holds.
    function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] c);
        if (&c) return {1'b1, c};
        return {1'b0, c + COUNT_W'(1)};
    endfunction

    cast_debounce #(.DEB_N(DEB_N)) u_cast_deb (
        .clk        (clk100MHz),
        .rst        (rst),
        .tick_en    (tick_en),
        .cast_raw   (cast),
        .cast_level (cast_level),
        .cast_rise  (cast_rise)
    );

    always_comb begin
        state_d      = state_q;
        ballot_d     = ballot_q;
        yes_d        = yes_q;
        result_d     = result_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        sat_d        = sat_q;
        sat_hit      = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            ST_IDLE:   if (cast_rise) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                ballot_d = vsync2_q;
                state_d  = ST_EVAL;
            end
            // result_valid marks the edge on which the new result and tally are written.
            ST_EVAL: begin
                result_valid = 1'b1;
                yes_d        = popcount(ballot_q);
                result_d     = decide(yes_d);
                if (result_d) {sat_hit, pass_d} = sat_inc(pass_q);
                else          {sat_hit, fail_d} = sat_inc(fail_q);
                if (sat_hit) sat_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD:   if (!cast_level) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (clr) begin
            pass_d = '0;
            fail_d = '0;
            sat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vsync1_q <= '0;
            vsync2_q <= '0;
            ballot_q <= '0;
            yes_q    <= '0;
            result_q <= 1'b0;
            pass_q   <= '0;
            fail_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vsync1_q <= vote_in;
            vsync2_q <= vsync1_q;
            ballot_q <= ballot_d;
            yes_q    <= yes_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            sat_q    <= sat_d;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign yes_cnt  = yes_q;
    assign result   = result_q;
    assign sat      = sat_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Directed bench for vote_tally_ctrl: five instances cover majority (3 and 4 voters),
// unanimous, any-yes and a 2-bit saturating tally, all driven by one cast/tick sequence.
module tb_vote_tally_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick_en, cast, clr;
    logic [2:0] v3, vm, va;
    logic [3:0] v4;

    logic [3:0] p0, f0, p1, f1, p2, f2, p4, f4;
    logic [1:0] p3, f3;
    logic [1:0] y0, y2, y3, y4;
    logic [2:0] y1;
    logic r0, rv0, b0, s0, r1, rv1, b1, s1, r2, rv2, b2, s2;
    logic r3, rv3, b3, s3, r4, rv4, b4, s4;

    vote_tally_ctrl #(.N_VOTERS(3), .COUNT_W(4), .MODE(0), .DEB_N(4)) d0 (
        .clk100MHz(clk), .rst(rst), .tick_en(tick_en), .vote_in(v3), .cast(cast), .clr(clr),
        .pass_cnt(p0), .fail_cnt(f0), .yes_cnt(y0), .result(r0), .result_valid(rv0),
        .busy(b0), .sat(s0));
    vote_tally_ctrl #(.N_VOTERS(4), .COUNT_W(4), .MODE(0), .DEB_N(4)) d1 (
        .clk100MHz(clk), .rst(rst), .tick_en(tick_en), .vote_in(v4), .cast(cast), .clr(clr),
        .pass_cnt(p1), .fail_cnt(f1), .yes_cnt(y1), .result(r1), .result_valid(rv1),
        .busy(b1), .sat(s1));
    vote_tally_ctrl #(.N_VOTERS(3), .COUNT_W(4), .MODE(1), .DEB_N(4)) d2 (
        .clk100MHz(clk), .rst(rst), .tick_en(tick_en), .vote_in(vm), .cast(cast), .clr(clr),
        .pass_cnt(p2), .fail_cnt(f2), .yes_cnt(y2), .result(r2), .result_valid(rv2),
        .busy(b2), .sat(s2));
    vote_tally_ctrl #(.N_VOTERS(3), .COUNT_W(2), .MODE(0), .DEB_N(4)) d3 (
        .clk100MHz(clk), .rst(rst), .tick_en(tick_en), .vote_in(v3), .cast(cast), .clr(clr),
        .pass_cnt(p3), .fail_cnt(f3), .yes_cnt(y3), .result(r3), .result_valid(rv3),
        .busy(b3), .sat(s3));
    vote_tally_ctrl #(.N_VOTERS(3), .COUNT_W(4), .MODE(2), .DEB_N(4)) d4 (
        .clk100MHz(clk), .rst(rst), .tick_en(tick_en), .vote_in(va), .cast(cast), .clr(clr),
        .pass_cnt(p4), .fail_cnt(f4), .yes_cnt(y4), .result(r4), .result_valid(rv4),
        .busy(b4), .sat(s4));

    int nvec = 0;
    int nerr = 0;
    int pulses = 0;
    int busy_cycles = 0;

    always @(negedge clk) begin
        if (rv0) pulses++;
        if (b0) busy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Each tick: three quiet cycles (lets the synchronizer settle) then one strobe cycle.
    // Returns on the falling edge just after the strobe was sampled.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clk);
            tick_en = 1'b1;
            @(negedge clk);
            tick_en = 1'b0;
        end
    endtask

    // Called right after the accepting tick: SAMPLE, then EVAL (pulse), then HOLD.
    task automatic window(input bit scramble, input bit clr_eval);
        @(negedge clk);
        chk("valid_before", rv0, 0);
        chk("busy_sample", b0, 1);
        if (scramble) begin
            v3 = ~v3; v4 = ~v4; vm = ~vm; va = ~va;
        end
        @(negedge clk);
        chk("valid_at_2", rv0, 1);
        if (clr_eval) clr = 1'b1;
        @(negedge clk);
        chk("valid_after", rv0, 0);
        clr = 1'b0;
    endtask

    task automatic round(input int hold, input bit scramble, input bit clr_eval);
        int p;
        p = pulses;
        cast = 1'b1;
        tick(4);
        window(scramble, clr_eval);
        tick(hold);
        cast = 1'b0;
        tick(5);
        chk("one_pulse", pulses - p, 1);
        chk("idle_after", b0, 0);
    endtask

    initial begin
        int p, bc;
        rst = 1'b1; tick_en = 1'b0; cast = 1'b0; clr = 1'b0;
        v3 = '0; v4 = '0; vm = '0; va = '0;
        repeat (3) @(negedge clk);
        chk("rst_pass", p0, 0); chk("rst_fail", f0, 0); chk("rst_yes", y0, 0);
        chk("rst_result", r0, 0); chk("rst_valid", rv0, 0); chk("rst_busy", b0, 0);
        chk("rst_sat", s0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Round 1: 10-tick hold, one round only
        v3 = 3'b110; v4 = 4'b0011; vm = 3'b111; va = 3'b000;
        round(6, 1'b0, 1'b0);
        chk("r1_pass0", p0, 1); chk("r1_fail0", f0, 0); chk("r1_yes0", y0, 2);
        chk("r1_res0", r0, 1);
        chk("r1_tie_res1", r1, 0); chk("r1_tie_fail1", f1, 1); chk("r1_yes1", y1, 2);
        chk("r1_unan_res2", r2, 1); chk("r1_any_res4", r4, 0); chk("r1_yes4", y4, 0);
        chk("r1_pass3", p3, 1);

        // Round 2: inputs inverted during SAMPLE must not reach this ballot
        v3 = 3'b011; v4 = 4'b0111; vm = 3'b011; va = 3'b001;
        round(1, 1'b1, 1'b0);
        chk("r2_pass0", p0, 2); chk("r2_yes0", y0, 2); chk("r2_res0", r0, 1);
        chk("r2_res1", r1, 1); chk("r2_pass1", p1, 1); chk("r2_yes1", y1, 3);
        chk("r2_unan_res2", r2, 0); chk("r2_fail2", f2, 1); chk("r2_yes2", y2, 2);
        chk("r2_any_res4", r4, 1); chk("r2_yes4", y4, 1);

        v3 = 3'b100; v4 = 4'b1111; vm = 3'b111; va = 3'b100;
        round(1, 1'b0, 1'b0);
        chk("r3_res0", r0, 0); chk("r3_fail0", f0, 1); chk("r3_pass0", p0, 2);
        chk("r3_yes0", y0, 1);
        chk("r3_res1", r1, 1); chk("r3_yes1", y1, 4); chk("r3_pass1", p1, 2);
        chk("r3_res2", r2, 1); chk("r3_pass2", p2, 2); chk("r3_yes2", y2, 3);
        chk("r3_fail3", f3, 1); chk("r3_pass3", p3, 2);

        // Rounds 4-6 drive the 2-bit tally to its ceiling and beyond
        v3 = 3'b111;
        round(1, 1'b0, 1'b0);
        chk("r4_pass3", p3, 3); chk("r4_sat3", s3, 0); chk("r4_yes0", y0, 3);
        round(1, 1'b0, 1'b0);
        chk("r5_pass3", p3, 3); chk("r5_sat3", s3, 1); chk("r5_pass0", p0, 4);
        chk("r5_sat0", s0, 0);
        round(1, 1'b0, 1'b0);
        chk("r6_pass3", p3, 3); chk("r6_sat3", s3, 1); chk("r6_pass0", p0, 5);
        chk("r6_fail0", f0, 1);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_pass3", p3, 0); chk("clr_sat3", s3, 0); chk("clr_fail3", f3, 0);
        chk("clr_pass0", p0, 0); chk("clr_fail0", f0, 0);

        // 3-tick glitches never reach the 4-sample threshold
        p = pulses; bc = busy_cycles;
        for (int k = 0; k < 3; k++) begin
            cast = 1'b1; tick(3);
            cast = 1'b0; tick(3);
        end
        chk("glitch_pulses", pulses - p, 0); chk("glitch_busy", busy_cycles - bc, 0);
        chk("glitch_pass0", p0, 0); chk("glitch_fail0", f0, 0);

        // Clear coincident with EVAL: result updates, tallies end at zero
        v3 = 3'b110;
        round(1, 1'b0, 1'b1);
        chk("clreval_res0", r0, 1); chk("clreval_yes0", y0, 2);
        chk("clreval_pass0", p0, 0); chk("clreval_fail0", f0, 0); chk("clreval_pass3", p3, 0);

        // Reset during SAMPLE with cast still held
        v3 = 3'b101;
        cast = 1'b1;
        tick(4);
        @(negedge clk);
        chk("pre_rst_busy", b0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pass", p0, 0); chk("mid_rst_fail", f0, 0); chk("mid_rst_yes", y0, 0);
        chk("mid_rst_result", r0, 0); chk("mid_rst_valid", rv0, 0);
        chk("mid_rst_busy", b0, 0); chk("mid_rst_sat", s0, 0);
        @(negedge clk);
        rst = 1'b0;
        p = pulses;
        tick(3);
        chk("rearm_busy", b0, 0); chk("rearm_pulses", pulses - p, 0);
        tick(1);
        window(1'b0, 1'b0);
        chk("rearm_res0", r0, 1); chk("rearm_yes0", y0, 2); chk("rearm_pass0", p0, 1);
        chk("rearm_fail0", f0, 0);
        cast = 1'b0;
        tick(5);
        chk("final_idle", b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vote_tally_ctrl.md
VOTE_TALLY_CTRL -- requirements
Module: vote_tally_ctrl

Interface
REQ-001 Parameter N_VOTERS, default 3, number of voter switch inputs (range 1..16).
REQ-002 Parameter COUNT_W, default 4, width of each round tally counter.
REQ-003 Parameter MODE, default 0, decision rule: 0 = strict majority, 1 = unanimous, 2 = any-yes.
REQ-004 Parameter DEB_N, default 4, number of consecutive agreeing tick samples required to accept a cast-button change.
REQ-005 clk100MHz  input  1  system clock; single clock domain; all logic is rising-edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 tick_en  input  1  one-cycle debounce sample strobe, e.g. the 5 kHz enable from the clock generator.
REQ-008 vote_in  input  N_VOTERS  raw voter switches; 1 = yes.
REQ-009 cast  input  1  raw cast pushbutton; asynchronous to clk100MHz.
REQ-010 clr  input  1  synchronous clear of tallies and the saturation flag.
REQ-011 pass_cnt  output  COUNT_W  number of rounds decided pass.
REQ-012 fail_cnt  output  COUNT_W  number of rounds decided fail.
REQ-013 yes_cnt  output  $clog2(N_VOTERS+1)  popcount of the last latched ballot.
REQ-014 result  output  1  decision of the last round; 1 = pass.
REQ-015 result_valid  output  1  one-cycle pulse when result, yes_cnt and the tallies update.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 sat  output  1  sticky flag; set when either tally saturates.

Function
REQ-018 vote_in and cast shall each pass through a 2-flop synchronizer before any other use.
REQ-019 Debounced cast shall change level only after DEB_N consecutive tick_en samples equal the new level; cycles without tick_en shall not advance the filter.
REQ-020 The FSM states shall be IDLE, SAMPLE, EVAL and HOLD.
REQ-021 IDLE -> SAMPLE on the debounced-cast rising edge; no other event leaves IDLE.
REQ-022 SAMPLE shall latch synchronized vote_in into the ballot register and go to EVAL after exactly one cycle.
REQ-023 EVAL shall compute yes_cnt = popcount(ballot), decide, update exactly one tally, pulse result_valid, and go to HOLD after exactly one cycle.
REQ-024 result_valid shall assert exactly 2 cycles after the cycle in which debounced cast rises.
REQ-025 Decision rules: MODE 0 passes when 2*yes_cnt > N_VOTERS, so a tie fails; MODE 1 passes when yes_cnt == N_VOTERS; MODE 2 passes when yes_cnt >= 1.
REQ-026 Tallies shall saturate at 2^COUNT_W-1 and never wrap; an increment attempted at the maximum shall set sat.
REQ-027 HOLD -> IDLE once debounced cast is low; a held button shall therefore count as exactly one round.
REQ-028 clr shall zero pass_cnt, fail_cnt and sat on the next edge, in any state.
REQ-029 If clr coincides with EVAL, the clear shall win and the tallies end at zero; result, yes_cnt and result_valid still update for that round.
REQ-030 vote_in changes after SAMPLE shall not affect the round in progress.
REQ-031 The decision logic and all arithmetic shall be unsigned, with yes_cnt width sufficient for N_VOTERS without overflow.

Reset
REQ-032 While rst is high: state = IDLE; pass_cnt, fail_cnt, yes_cnt, result, result_valid, busy, sat and the ballot register = 0.
REQ-033 While rst is high, the synchronizers and debounce filter shall be 0, so the debounced cast level is low.
REQ-034 Reset asserted mid-round shall abandon the round with no tally update; after release, a still-held button shall be seen as a new rising edge only after DEB_N high samples.

Structure
REQ-035 Package vote_pkg shall hold the FSM state typedef and the MODE constants (MODE_MAJORITY, MODE_UNANIMOUS, MODE_ANY).
REQ-036 Sub-module cast_debounce (synchronizer, DEB_N filter, rising-edge pulse) shall be instantiated once for cast.
REQ-037 The popcount, decision and tally logic shall stay inside vote_tally_ctrl; the display path (bcd_to_7seg, led_mux) lies outside this block.

Verification
REQ-038 Defaults, vote_in=3'b110, cast held high for 10 ticks -> one result_valid pulse, result=1, yes_cnt=2, pass_cnt=1, fail_cnt=0.
REQ-039 cast toggling with 3-tick pulses while DEB_N=4 -> no state change, busy stays 0, tallies unchanged.
REQ-040 MODE=0, N_VOTERS=4, ballot 4'b0011 -> result=0 (tie), fail_cnt increments; MODE=1 with ballot 3'b111 -> pass, ballot 3'b011 -> fail.
REQ-041 COUNT_W=2, 5 passing rounds -> pass_cnt holds at 3, sat=1 after round 4; clr -> pass_cnt=0 and sat=0.
REQ-042 clr asserted in the EVAL cycle -> result_valid pulses, both tallies read 0 afterwards.
REQ-043 rst pulsed during SAMPLE -> all outputs 0, no tally change; the held cast is re-accepted only after 4 high ticks.
